// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// Optional ack timeout is enabled by defining RESET_SEQ_TIMEOUT_EN.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    WAIT_ACK  = 3'd3,
    DONE      = 3'd4
  } reset_seq_state_t;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 8;
  localparam int MAX_COUNT  = 65535;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for one level signal; both flops clear to 0 on reset_async.
module bit_synchronizer (
  input  logic clk,
  input  logic reset_async,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous level into the clk domain.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset outputs in ascending order once the PLL is locked.
// Define RESET_SEQ_TIMEOUT_EN to build the per-stage ack timeout and timeout_err flag.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_async,
  input  logic                  pll_locked,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic                  timeout_err
);

  localparam int IDX_W = cnt_width(NUM_STAGES);
  // One counter width covers both the hold and the ack-timeout range.
  localparam int CNT_W = cnt_width((HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  logic                  lock_sync;
  logic [NUM_STAGES-1:0] ack_sync;

  bit_synchronizer u_lock_sync (
    .clk         (clk),
    .reset_async (reset_async),
    .d           (pll_locked),
    .q           (lock_sync)
  );

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_ack_sync
    bit_synchronizer u_ack_sync (
      .clk         (clk),
      .reset_async (reset_async),
      .d           (stage_ack[g]),
      .q           (ack_sync[g])
    );
  end

  reset_seq_state_t      state, state_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [CNT_W-1:0]      hold_cnt, hold_cnt_next;
  logic [NUM_STAGES-1:0] rst_next;
  logic                  advance;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic [CNT_W-1:0] ack_cnt, ack_cnt_next;
  logic             tmo_hit;

  // Ack wait counter; a timeout counts as an ack, and lock loss suppresses both.
  always_comb begin
    ack_cnt_next = {CNT_W{1'b0}};
    tmo_hit      = 1'b0;
    if ((state == WAIT_ACK) && lock_sync && !ack_sync[idx]) begin
      if (ack_cnt == ACK_LAST) begin
        tmo_hit = 1'b1;
      end else begin
        ack_cnt_next = ack_cnt + CNT_W'(1);
      end
    end else begin
      ack_cnt_next = {CNT_W{1'b0}};
    end
  end

  assign advance = ack_sync[idx] | tmo_hit;

  // Timeout counter and sticky error flag; lock loss leaves the flag alone.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      ack_cnt     <= {CNT_W{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      ack_cnt     <= ack_cnt_next;
      timeout_err <= timeout_err | tmo_hit;
    end
  end
`else
  assign advance     = ack_sync[idx];
  assign timeout_err = 1'b0;
`endif

  // Next-state and next-output decode; lock loss overrides every other transition.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    hold_cnt_next = hold_cnt;
    rst_next      = rst_out;
    if ((state != WAIT_LOCK) && !lock_sync) begin
      state_next    = WAIT_LOCK;
      idx_next      = {IDX_W{1'b0}};
      hold_cnt_next = {CNT_W{1'b0}};
      rst_next      = {NUM_STAGES{1'b1}};
    end else begin
      case (state)
        WAIT_LOCK: begin
          rst_next = {NUM_STAGES{1'b1}};
          if (lock_sync) begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_LOAD;
          end else begin
            hold_cnt_next = {CNT_W{1'b0}};
          end
        end
        HOLD: begin
          if (hold_cnt == {CNT_W{1'b0}}) begin
            state_next = RELEASE;
            idx_next   = {IDX_W{1'b0}};
          end else begin
            hold_cnt_next = hold_cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          rst_next[idx] = 1'b0;
          state_next    = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!advance) begin
            state_next = WAIT_ACK;
          end else if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = RELEASE;
          end
        end
        DONE: begin
          rst_next = {NUM_STAGES{1'b0}};
        end
        default: begin
          state_next    = WAIT_LOCK;
          idx_next      = {IDX_W{1'b0}};
          hold_cnt_next = {CNT_W{1'b0}};
          rst_next      = {NUM_STAGES{1'b1}};
        end
      endcase
    end
  end

  // State, index, hold counter and registered outputs.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      state    <= WAIT_LOCK;
      idx      <= {IDX_W{1'b0}};
      hold_cnt <= {CNT_W{1'b0}};
      rst_out  <= {NUM_STAGES{1'b1}};
      seq_done <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      hold_cnt <= hold_cnt_next;
      rst_out  <= rst_next;
      seq_done <= (state_next == DONE);
    end
  end

endmodule
